// File: rtl/spi_word_fetcher_if.sv
// Host request/response and byte-wide flash port bundle for spi_word_fetcher.
// master: the fetcher itself; slave: host plus flash block.
interface spi_word_fetcher_if;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        cs;
    logic        readMem;
    logic [23:0] addressBus;
    logic [7:0]  dataIn;
    logic        ready;
    logic [7:0]  dataOut;

    modport master (
        input  req, we, addr, wdata, ready, dataOut,
        output busy, done, err, rdata, cs, readMem, addressBus, dataIn
    );

    modport slave (
        output req, we, addr, wdata, ready, dataOut,
        input  busy, done, err, rdata, cs, readMem, addressBus, dataIn
    );
endinterface

// File: rtl/spi_word_fetcher.sv
// Splits a word read into WORD_BYTES single-byte flash reads (little-endian assembly),
// forwards single-byte writes, and aborts any byte that waits too long for ready.
module spi_word_fetcher #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned TO_W       = 13
) (
    input logic                 clk,
    input logic                 rst,
    spi_word_fetcher_if.master  bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StGap, StAbort, StDone} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [23:0]       base_q, base_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              abort_q, abort_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            to_q     <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        to_d     = to_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        abort_d  = abort_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    we_d     = bus.we;
                    base_d   = bus.addr;
                    wdata_d  = bus.wdata;
                    idx_d    = '0;
                    shadow_d = '0;
                    abort_d  = 1'b0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                to_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                to_d = to_q + 1'b1;
                // ready has priority over an expiring timeout in the same cycle
                if (bus.ready) begin
                    if (!we_q) begin
                        shadow_d[{idx_q, 3'b000} +: 8] = bus.dataOut;
                    end
                    state_d = StGap;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = StAbort;
                end
            end
            StGap: begin
                if (!bus.ready) begin
                    if (we_q || idx_q == 2'(WORD_BYTES - 1)) begin
                        // Publish the whole word at once so rdata is valid alongside done
                        if (!we_q) begin
                            rdata_d = shadow_q;
                        end
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StAbort: begin
                abort_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    logic cs_w;
    assign cs_w = (state_q == StIssue) || (state_q == StWait);

    assign bus.cs         = cs_w;
    assign bus.readMem    = cs_w & ~we_q;
    assign bus.addressBus = base_q + {22'd0, idx_q};
    assign bus.dataIn     = wdata_q;
    assign bus.busy       = (state_q == StIssue) || (state_q == StWait) ||
                            (state_q == StGap)   || (state_q == StAbort);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = (state_q == StDone) & abort_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_spi_word_fetcher.sv
// Randomised self-checking bench for spi_word_fetcher against a transaction-level flash model.
module tb_spi_word_fetcher;

    localparam int unsigned WB = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_word_fetcher_if bus ();

    spi_word_fetcher #(
        .WORD_BYTES (WB),
        .TIMEOUT    (TO),
        .TO_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash contents as the reference sees them; unwritten bytes follow a fixed pattern.
    bit [7:0] mem [bit [23:0]];
    function automatic bit [7:0] mem_rd(input bit [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Flash responder: random latency, ready held until cs drops plus a random tail.
    bit hang      = 1'b0;
    int fixed_lat = -1;
    initial begin
        int  lat;
        int  hold;
        bit  started;
        lat = 0; hold = 0; started = 1'b0;
        bus.ready   = 1'b0;
        bus.dataOut = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                bus.ready = 1'b0;
                started   = 1'b0;
                hold      = 0;
            end else if (bus.ready) begin
                if (!bus.cs) begin
                    if (hold > 0) hold--;
                    else bus.ready = 1'b0;
                end
            end else if (bus.cs && !hang) begin
                if (!started) begin
                    started = 1'b1;
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (lat > 0) begin
                    lat--;
                end else begin
                    bus.dataOut = bus.readMem ? mem_rd(bus.addressBus) : 8'h00;
                    bus.ready   = 1'b1;
                    hold        = int'($urandom_range(0, 2));
                    started     = 1'b0;
                end
            end
        end
    end

    // Burst log: one entry per cs-high window.
    typedef struct {
        logic [23:0] a;
        logic        rm;
        logic [7:0]  d;
        int          len;
        bit          stable;
    } burst_t;
    burst_t bursts[$];
    int     done_cnt = 0;
    initial begin
        burst_t cur;
        bit     in_b;
        in_b = 1'b0;
        cur  = '{a: 24'h0, rm: 1'b0, d: 8'h0, len: 0, stable: 1'b1};
        forever begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.cs === 1'b1) begin
                if (!in_b) begin
                    cur  = '{a: bus.addressBus, rm: bus.readMem, d: bus.dataIn, len: 1, stable: 1'b1};
                    in_b = 1'b1;
                end else begin
                    cur.len++;
                    if (bus.addressBus !== cur.a || bus.readMem !== cur.rm || bus.dataIn !== cur.d)
                        cur.stable = 1'b0;
                end
            end else if (in_b) begin
                bursts.push_back(cur);
                in_b = 1'b0;
            end
        end
    end

    logic [31:0] exp_rdata = 32'h0;

    // One host transaction; caller is at #1 after a posedge with the DUT idle.
    task automatic run_txn(input bit we, input bit [23:0] a, input bit [7:0] wd, input bit hng);
        int          cyc;
        int          nexp;
        logic [31:0] word;
        hang = hng;
        bursts.delete();
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {31'd0, bus.done}, 32'd1);

        word = 32'h0;
        if (hng) begin
            nexp = 1;
        end else if (we) begin
            nexp = 1;
            mem[a] = wd;
        end else begin
            nexp = WB;
            for (int i = 0; i < int'(WB); i++) word |= 32'(mem_rd(a + 24'(i))) << (8 * i);
            exp_rdata = word;
        end

        check("err", {31'd0, bus.err}, {31'd0, hng});
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("rdata_at_done", bus.rdata, exp_rdata);
        check("n_bursts", bursts.size(), nexp);
        for (int i = 0; i < nexp && i < bursts.size(); i++) begin
            check("burst_addr", {8'h0, bursts[i].a}, {8'h0, a + 24'(i)});
            check("burst_readmem", {31'd0, bursts[i].rm}, {31'd0, ~we});
            check("burst_stable", {31'd0, bursts[i].stable}, 32'd1);
            if (we) check("burst_wdata", {24'h0, bursts[i].d}, {24'h0, wd});
            if (hng) check("timeout_cs_len", bursts[i].len, TO + 1);
        end
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("rdata_held", bus.rdata, exp_rdata);
        hang = 1'b0;
    endtask

    initial begin
        int cyc;
        int d0;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 24'h000100;
        bus.wdata = 8'h00;

        // Reset held with req asserted: everything stays at zero
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_cs", {31'd0, bus.cs}, 32'd0);
            check("rst_busy", {31'd0, bus.busy}, 32'd0);
            check("rst_done", {31'd0, bus.done}, 32'd0);
            check("rst_err", {31'd0, bus.err}, 32'd0);
            check("rst_rdata", bus.rdata, 32'd0);
            check("rst_readmem", {31'd0, bus.readMem}, 32'd0);
            check("rst_addr", {8'h0, bus.addressBus}, 32'd0);
            check("rst_datain", {24'h0, bus.dataIn}, 32'd0);
        end
        bus.req = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;

        mem[24'h000100] = 8'h11; mem[24'h000101] = 8'h22;
        mem[24'h000102] = 8'h33; mem[24'h000103] = 8'h44;
        mem[24'hFFFFFE] = 8'hAA; mem[24'hFFFFFF] = 8'hBB;
        mem[24'h000000] = 8'hCC; mem[24'h000001] = 8'hDD;

        run_txn(1'b0, 24'h000100, 8'h00, 1'b0);
        check("word_read_value", bus.rdata, 32'h44332211);
        run_txn(1'b0, 24'hFFFFFE, 8'h00, 1'b0);
        check("wrap_read_value", bus.rdata, 32'hDDCCBBAA);
        run_txn(1'b1, 24'h000010, 8'h5A, 1'b0);
        run_txn(1'b0, 24'h000010, 8'h00, 1'b0);
        check("write_readback_b0", {24'h0, bus.rdata[7:0]}, 32'h5A);
        run_txn(1'b0, 24'h000300, 8'h00, 1'b1);
        run_txn(1'b1, 24'h000301, 8'h77, 1'b1);
        run_txn(1'b0, 24'h000300, 8'h00, 1'b0);

        // Reset while byte 2 of a read is waiting on the flash
        fixed_lat = 10;
        bursts.delete();
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 24'h000200;
        @(posedge clk); #1;
        bus.req = 1'b0;
        cyc = 0;
        while (!(bursts.size() == 2 && bus.cs === 1'b1) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_reached_byte2", {31'd0, bus.cs}, 32'd1);
        @(posedge clk); #1;
        d0  = done_cnt;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_cs", {31'd0, bus.cs}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        rst       = 1'b1;
        exp_rdata = 32'h0;
        fixed_lat = -1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        check("midrst_rdata_cleared", bus.rdata, 32'h0);
        run_txn(1'b0, 24'h000200, 8'h00, 1'b0);

        // Random traffic, biased toward the top of the address space
        for (int t = 0; t < 30; t++) begin
            bit [23:0] a;
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                            : 24'($urandom_range(0, 32'h3F));
            run_txn(bit'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
